// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline stage register with optional skid slot, flush and bubble counter
module pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             bubble,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_bubble;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_bubble_cyc;

  assign w_out_valid = (r_state != ST_EMPTY);

  // Skid mode keeps in_ready purely state-derived so no path exists from out_ready.
  generate
    if (SKID != 0) begin : g_skid
      assign w_in_ready = (r_state != ST_SKID);
    end else begin : g_noskid
      assign w_in_ready = !w_out_valid | out_ready;
    end
  endgenerate

  assign w_in_fire    = in_valid & w_in_ready;
  assign w_out_fire   = w_out_valid & out_ready;
  assign w_bubble_cyc = out_ready & !w_out_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (w_out_fire && w_in_fire) begin
            w_main_nxt = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_fire) begin
            w_state_nxt = ST_SKID;
            w_skid_nxt  = in_data;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= (SKID != 0) ? w_skid_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble     <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      r_bubble <= w_bubble_cyc;
      if (w_bubble_cyc && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = r_main;
  assign bubble     = r_bubble;
  assign occupancy  = r_state;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed vector bench for pipe_stage in skid and non-skid modes
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_bubble;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_bubble;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .bubble(a_bubble), .occupancy(a_occ), .bubble_cnt(a_cnt)
  );

  pipe_stage #(.WIDTH(32), .SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .bubble(b_bubble), .occupancy(b_occ), .bubble_cnt(b_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic        e_bub;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 32'h1, 1'b1, 2'd1, 1'b0};
    for (int k = 2; k <= 8; k++)
      tbl[k-1] = '{1'b1, 32'(k), 1'b1, 1'b0, 1'b1, 32'(k), 1'b1, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 32'hA,    1'b0, 1'b0, 1'b1, 32'hA,  1'b1, 2'd1, 1'b0};
    tbl[11] = '{1'b1, 32'hB,    1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 2'd2, 1'b0};
    tbl[12] = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 32'hA,  1'b0, 2'd2, 1'b0};
    tbl[14] = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 32'hB,  1'b1, 2'd1, 1'b0};
    tbl[15] = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 32'hC,  1'b1, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'hC,  1'b1, 2'd0, 1'b0};
    tbl[17] = '{1'b1, 32'h11,   1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{1'b1, 32'h22,   1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 1'b0};
    tbl[19] = '{1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0};
    tbl[20] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1};
    tbl[21] = '{1'b1, 32'h33,   1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 2'd1, 1'b0};
    tbl[22] = '{1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst out_valid", 32'(a_out_valid), 32'd0);
    chk("rst out_data",  a_out_data, 32'd0);
    chk("rst occupancy", 32'(a_occ), 32'd0);
    chk("rst in_ready",  32'(a_in_ready), 32'd1);
    chk("rst bubble",    32'(a_bubble), 32'd0);
    chk("rst bubble_cnt",32'(a_cnt), 32'd0);
    chk("rst noskid in_ready", 32'(b_in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, backpressure and flush sequences on the skid instance.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d out_valid", i), 32'(a_out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_data", i),  a_out_data, tbl[i].e_data);
      chk($sformatf("vec%0d in_ready", i),  32'(a_in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d occupancy", i), 32'(a_occ), 32'(tbl[i].e_occ));
      chk($sformatf("vec%0d bubble", i),    32'(a_bubble), 32'(tbl[i].e_bub));
    end

    // Asynchronous reset while holding two entries.
    do_reset();
    step(1'b1, 32'h71, 1'b0, 1'b0);
    step(1'b1, 32'h72, 1'b0, 1'b0);
    chk("pre-reset occupancy", 32'(a_occ), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(a_out_valid), 32'd0);
    chk("async rst out_data",  a_out_data, 32'd0);
    chk("async rst occupancy", 32'(a_occ), 32'd0);
    chk("async rst bubble_cnt",32'(a_cnt), 32'd0);
    chk("async rst in_ready",  32'(a_in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    // Saturating bubble counter with CNT_W=4.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("bub%0d bubble", i), 32'(a_bubble), 32'd1);
      chk($sformatf("bub%0d bubble_cnt", i), 32'(a_cnt), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
    end

    // Non-skid instance: combinational in_ready tracks out_ready while FULL.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h50; out_ready = 1'b1;
    #1;
    chk("noskid empty in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    chk("noskid data 50", b_out_data, 32'h50);
    chk("noskid occ 1a", 32'(b_occ), 32'd1);
    @(negedge clk);
    out_ready = 1'b0; in_data = 32'h51;
    #1;
    chk("noskid in_ready low", 32'(b_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("noskid hold data", b_out_data, 32'h50);
    chk("noskid occ 1b", 32'(b_occ), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("noskid in_ready high", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    chk("noskid data 51", b_out_data, 32'h51);
    chk("noskid occ 1c", 32'(b_occ), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
